// File: rtl/satvsmt_ff_readback_if.sv
// Handshake bundle between a SATVSMT_FF flop bank and its snapshot reader.
// The reader takes the slave modport.
interface satvsmt_ff_readback_if #(
  parameter int WIDTH = 8
);
  logic             SNAP;
  logic [WIDTH-1:0] ST;
  logic             DR;
  logic             DO;
  logic             DV;
  logic             LAST;
  logic             BUSY;
  logic             DROP;

  modport master (
    output SNAP, ST, DR,
    input  DO, DV, LAST, BUSY, DROP
  );

  modport slave (
    input  SNAP, ST, DR,
    output DO, DV, LAST, BUSY, DROP
  );
endinterface

// File: rtl/satvsmt_ff_readback.sv
// Captures a SATVSMT_FF state bank into a shadow register and unloads it
// LSB-first over a valid/ready serial stream, with an optional even-parity beat.
module satvsmt_ff_readback #(
  parameter int WIDTH  = 8,
  parameter bit PARITY = 1'b0
) (
  input  logic                   CLK,
  input  logic                   LSR_N,
  satvsmt_ff_readback_if.slave   bus
);

  localparam int             CW      = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  C_WIDTH = CW'(WIDTH);
  localparam logic [CW-1:0]  C_FINAL = PARITY ? CW'(WIDTH) : CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt;
  logic             r_par, w_par_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_drop, w_drop_nxt;
  logic             w_xfer;
  logic             w_final;
  logic             w_dv;

  assign w_dv    = (r_state == S_SHIFT);
  assign w_final = (r_cnt == C_FINAL);
  assign w_xfer  = w_dv && bus.DR;

  always_ff @(posedge CLK or negedge LSR_N) begin
    if (!LSR_N) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_par    <= 1'b0;
      r_cnt    <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_par    <= w_par_nxt;
      r_cnt    <= w_cnt_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_par_nxt    = r_par;
    w_cnt_nxt    = r_cnt;
    w_drop_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.SNAP) begin
          w_shadow_nxt = bus.ST;
          w_par_nxt    = ^bus.ST;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_xfer && w_final) begin
          // A request landing on the last transfer chains the next frame with no bubble.
          if (bus.SNAP) begin
            w_shadow_nxt = bus.ST;
            w_par_nxt    = ^bus.ST;
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end else begin
          if (w_xfer) begin
            w_shadow_nxt = r_shadow >> 1;
            w_cnt_nxt    = r_cnt + 1'b1;
          end
          w_drop_nxt = bus.SNAP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Beats past the data bits can only be the parity beat.
  assign bus.DO   = w_dv && ((r_cnt < C_WIDTH) ? r_shadow[0] : r_par);
  assign bus.DV   = w_dv;
  assign bus.BUSY = w_dv;
  assign bus.LAST = w_dv && w_final;
  assign bus.DROP = r_drop;

endmodule

// File: tb/tb_satvsmt_ff_readback.sv
// Directed bench for satvsmt_ff_readback: four instances cover WIDTH 8/1
// with PARITY 0/1; table-driven frames plus hand-written corner sequences.
module tb_satvsmt_ff_readback;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       snap [4];
  logic [7:0] st_v [4];
  logic       dr   [4];
  logic       dout [4];
  logic       dv   [4];
  logic       last [4];
  logic       busy [4];
  logic       drop [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  satvsmt_ff_readback_if #(.WIDTH(8)) if0 ();
  satvsmt_ff_readback_if #(.WIDTH(8)) if1 ();
  satvsmt_ff_readback_if #(.WIDTH(1)) if2 ();
  satvsmt_ff_readback_if #(.WIDTH(1)) if3 ();

  satvsmt_ff_readback #(.WIDTH(8), .PARITY(1'b0)) u0 (.CLK(clk), .LSR_N(rst_n), .bus(if0.slave));
  satvsmt_ff_readback #(.WIDTH(8), .PARITY(1'b1)) u1 (.CLK(clk), .LSR_N(rst_n), .bus(if1.slave));
  satvsmt_ff_readback #(.WIDTH(1), .PARITY(1'b0)) u2 (.CLK(clk), .LSR_N(rst_n), .bus(if2.slave));
  satvsmt_ff_readback #(.WIDTH(1), .PARITY(1'b1)) u3 (.CLK(clk), .LSR_N(rst_n), .bus(if3.slave));

  assign if0.SNAP = snap[0];  assign if0.ST = st_v[0];     assign if0.DR = dr[0];
  assign if1.SNAP = snap[1];  assign if1.ST = st_v[1];     assign if1.DR = dr[1];
  assign if2.SNAP = snap[2];  assign if2.ST = st_v[2][0];  assign if2.DR = dr[2];
  assign if3.SNAP = snap[3];  assign if3.ST = st_v[3][0];  assign if3.DR = dr[3];

  assign dout[0] = if0.DO; assign dv[0] = if0.DV; assign last[0] = if0.LAST; assign busy[0] = if0.BUSY; assign drop[0] = if0.DROP;
  assign dout[1] = if1.DO; assign dv[1] = if1.DV; assign last[1] = if1.LAST; assign busy[1] = if1.BUSY; assign drop[1] = if1.DROP;
  assign dout[2] = if2.DO; assign dv[2] = if2.DV; assign last[2] = if2.LAST; assign busy[2] = if2.BUSY; assign drop[2] = if2.DROP;
  assign dout[3] = if3.DO; assign dv[3] = if3.DV; assign last[3] = if3.LAST; assign busy[3] = if3.BUSY; assign drop[3] = if3.DROP;

  typedef struct {
    int         sel;
    logic [7:0] st;
    logic [8:0] exp;   // bit i = expected DO on beat i
    int         len;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int s, input logic [7:0] stv);
    snap[s] = 1'b1;
    st_v[s] = stv;
    tick();
    snap[s] = 1'b0;
    st_v[s] = 8'h5A;   // later ST changes must not matter
  endtask

  // Walks one frame already captured; stall bit i holds DR low once on beat i;
  // snap_beat >= 0 pulses SNAP (with snap_st) during that beat.
  task automatic do_frame(input int s, input logic [8:0] expv, input int len,
                          input logic [8:0] stall, input int snap_beat,
                          input logic [7:0] snap_st, input int exp_cycles);
    int   beat = 0;
    int   cyc = 0;
    logic stalled = 1'b0;
    logic snapped = 1'b0;
    logic drop_exp = 1'b0;
    logic snap_now;
    logic dr_now;
    while (beat < len && cyc < 40) begin
      chk("dv", dv[s], 1'b1);
      chk("do", dout[s], expv[beat]);
      chk("last", last[s], (beat == len - 1));
      chk("drop", drop[s], drop_exp);
      snap_now = (beat == snap_beat) && !snapped;
      if (snap_now) begin
        snap[s] = 1'b1;
        st_v[s] = snap_st;
        snapped = 1'b1;
      end
      dr_now = !(stall[beat] && !stalled);
      dr[s]  = dr_now;
      tick();
      snap[s]  = 1'b0;
      dr[s]    = 1'b1;
      drop_exp = snap_now && !(dr_now && beat == len - 1);
      if (dr_now) begin
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      cyc++;
    end
    chk("frame_cycles", cyc, exp_cycles);
  endtask

  task automatic chk_idle(input int s);
    chk("idle_dv", dv[s], 1'b0);
    chk("idle_busy", busy[s], 1'b0);
    chk("idle_last", last[s], 1'b0);
  endtask

  initial begin
    vt[0] = '{sel: 0, st: 8'hA5, exp: 9'h0A5, len: 8};
    vt[1] = '{sel: 1, st: 8'h07, exp: 9'h107, len: 9};
    vt[2] = '{sel: 1, st: 8'h03, exp: 9'h003, len: 9};
    vt[3] = '{sel: 0, st: 8'h3C, exp: 9'h03C, len: 8};
    vt[4] = '{sel: 1, st: 8'h80, exp: 9'h180, len: 9};
    vt[5] = '{sel: 2, st: 8'h01, exp: 9'h001, len: 1};
    vt[6] = '{sel: 3, st: 8'h01, exp: 9'h003, len: 2};

    for (int i = 0; i < 4; i++) begin
      snap[i] = 1'b0;
      st_v[i] = 8'h00;
      dr[i]   = 1'b1;
    end

    #2;
    for (int i = 0; i < 4; i++) begin
      chk("rst_do", dout[i], 1'b0);
      chk("rst_dv", dv[i], 1'b0);
      chk("rst_last", last[i], 1'b0);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_drop", drop[i], 1'b0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      start(vt[i].sel, vt[i].st);
      do_frame(vt[i].sel, vt[i].exp, vt[i].len, 9'h000, -1, 8'h00, vt[i].len);
      chk_idle(vt[i].sel);
      tick();
    end

    // Backpressure on beats 3 and 6
    start(0, 8'hA5);
    do_frame(0, 9'h0A5, 8, 9'b000100100, -1, 8'h00, 10);
    chk_idle(0);
    tick();

    // SNAP mid-frame is dropped, frame unaltered
    start(0, 8'hA5);
    do_frame(0, 9'h0A5, 8, 9'h000, 3, 8'h00, 8);
    chk_idle(0);
    chk("drop_clear", drop[0], 1'b0);
    tick();

    // SNAP on the final-transfer edge chains the next frame with no gap
    start(0, 8'hA5);
    do_frame(0, 9'h0A5, 8, 9'h000, 7, 8'h3C, 8);
    do_frame(0, 9'h03C, 8, 9'h000, -1, 8'h00, 8);
    chk_idle(0);
    tick();

    // Reset asserted mid-frame, between clock edges
    start(0, 8'hA5);
    repeat (4) tick();
    chk("pre_rst_dv", dv[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dv", dv[0], 1'b0);
    chk("async_rst_last", last[0], 1'b0);
    chk("async_rst_busy", busy[0], 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_dv", dv[0], 1'b0);
    chk("post_rst_drop", drop[0], 1'b0);
    start(0, 8'hFF);
    do_frame(0, 9'h0FF, 8, 9'h000, -1, 8'h00, 8);
    chk_idle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/satvsmt_ff_readback.md
# satvsmt_ff_readback

Snapshot-and-unload reader for a bank of SATVSMT_FF state registers. On request it captures the parallel Q outputs of up to WIDTH flip-flops into a shadow register in one cycle. It then shifts the captured bits out LSB-first over a valid/ready serial stream, with an optional even-parity bit at the end. It sits next to the flop bank in the SAT/SMT test designs, so state can be read back without disturbing the flops.

## Interface
- WIDTH, 8: number of state bits captured per snapshot; legal range 1..64.
- PARITY, 0: 1 appends an even-parity bit after the data bits, so the frame is WIDTH+1 beats; 0 makes the frame WIDTH beats.

- CLK  input  1  rising-edge clock for all state.
- LSR_N  input  1  asynchronous, active-low reset.
- SNAP  input  1  capture request, sampled on the CLK rising edge.
- ST  input  WIDTH  parallel state from the flop bank; sampled only on an accepted SNAP.
- DR  input  1  downstream ready.
- DO  output  1  serial data beat.
- DV  output  1  DO valid.
- LAST  output  1  high with the final beat of a frame.
- BUSY  output  1  high while a frame is pending or in flight.
- DROP  output  1  one-cycle pulse when a SNAP was rejected.

## Operation
- State machine with two states, IDLE and SHIFT. Reset enters IDLE.
- Registers:
  - shadow[WIDTH-1:0]
  - par: running even parity of the captured bits
  - cnt: beat index, width clog2(WIDTH+2), no wrap inside a frame
- IDLE behaviour:
  - DV=0, BUSY=0.
  - SNAP=1 means shadow<=ST, par<=^ST, cnt<=0, and the state goes to SHIFT.
- SHIFT behaviour:
  - DV=1 and BUSY=1.
  - DO=shadow[0] while cnt<WIDTH.
  - DO=par on the parity beat, which exists only when PARITY=1 and cnt==WIDTH.
- A transfer happens on a rising edge with DV=1 and DR=1. On each transfer, shadow shifts right with a 0 fill and cnt increments.
- Final beat: cnt==WIDTH-1 when PARITY=0, or cnt==WIDTH when PARITY=1.
  - LAST = DV && final beat.
  - On the final transfer the state returns to IDLE.
- When DR=0, DO, DV, LAST and cnt hold. DV never drops mid-frame except on reset.
- SNAP while in SHIFT, other than on the final-transfer edge:
  - The request is ignored and shadow is not disturbed.
  - DROP=1 for exactly the next cycle.
- SNAP on the final-transfer edge is accepted back-to-back:
  - The new snapshot is captured, cnt<=0, and the state stays in SHIFT.
  - DV stays high with no bubble and DROP stays 0.
- Changes on ST outside an accepted SNAP have no effect.

## Timing
- Reset values (asynchronous on LSR_N=0): DO=0, DV=0, LAST=0, BUSY=0, DROP=0, shadow=0, par=0, cnt=0, state=IDLE.
- Release of LSR_N takes effect at the next rising edge of CLK.
- Latency: SNAP sampled at edge k gives DV=1 and DO=ST[0] in the cycle after edge k.
- With DR held high, a frame occupies WIDTH (+1 if PARITY) consecutive cycles. Maximum throughput is one beat per cycle and one frame per frame-length cycles with no idle gap.
- All outputs are registered or decoded from registers only. There is no combinational path from SNAP, DR or ST to any output.
- Reset asserted mid-frame: the frame is abandoned and DV falls asynchronously. After reset there is no DROP and no partial resume.

## Test plan
- Basic frame, WIDTH=8, PARITY=0, DR=1, ST=8'hA5, SNAP for one cycle:
  - DO sequence is 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - LAST is high on the 8th beat only.
  - BUSY falls after the 8th beat.
- Backpressure, same frame with DR=0 on beats 3 and 6:
  - DO, DV and cnt hold during each stall.
  - The full sequence is unchanged and takes 10 cycles total.
- Parity, PARITY=1, ST=8'h07:
  - DO sequence is 1,1,1,0,0,0,0,0, then a parity beat of 1.
  - LAST is high on beat 9.
  - Repeat with ST=8'h03: parity beat is 0.
- Collisions:
  - SNAP pulsed during beat 4 gives DROP=1 for one cycle and the frame is unaltered.
  - SNAP on the final-transfer edge with ST=8'h3C gives the next cycle DV=1, DO=0 (bit 0 of 3C), and no gap.
- Reset mid-frame:
  - LSR_N pulled low during beat 5 makes DV, LAST and BUSY 0 immediately, with no clock edge required.
  - After release, a new SNAP with ST=8'hFF yields eight 1s.
- WIDTH=1 corner:
  - ST=1'b1 with PARITY=0 gives a single beat with DO=1 and LAST=1.
  - With PARITY=1 it gives beats 1 and 1, with LAST on the second beat.
